// File: rtl/conv_window_loader.sv
// Feeder for the 4-tap convolution: loads h0..h3, then presents sliding 4-sample windows.
// Optional: define CONV_LOADER_WIN_CNT_EN to add the win_count window-transfer counter.
module conv_window_loader #(
    parameter int DATA_W = 6,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kload,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] h0,
    output logic [DATA_W-1:0] h1,
    output logic [DATA_W-1:0] h2,
    output logic [DATA_W-1:0] h3,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic              win_valid,
    input  logic              win_ready
`ifdef CONV_LOADER_WIN_CNT_EN
    ,
    output logic [15:0]       win_count
`endif
);

    localparam logic [1:0] K_LOAD  = 2'd0;
    localparam logic [1:0] D_FILL  = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] SLIDE   = 2'd3;
    localparam logic [2:0] SLIDE_LAST = 3'(STRIDE - 1);

    generate
        if (STRIDE < 1 || STRIDE > 4) begin : g_bad_stride
            $error("conv_window_loader: STRIDE must be in 1..4");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_h [4];
    logic [DATA_W-1:0] r_x [4];
    logic              w_in_xfer;
    logic              w_win_xfer;
    logic              w_shift;
    logic              w_klast;

    // No bypass: input is refused while a window is on offer.
    assign in_ready   = !rst && !kload && (r_state != PRESENT);
    assign win_valid  = (r_state == PRESENT);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_win_xfer = win_valid && win_ready && !kload;
    assign w_shift    = w_in_xfer && (r_state == D_FILL || r_state == SLIDE);
    assign w_klast    = w_in_xfer && (r_state == K_LOAD) && (r_cnt == 3'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= K_LOAD;
            r_cnt   <= '0;
        end else if (kload) begin
            r_state <= K_LOAD;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                K_LOAD: if (w_in_xfer) begin
                    if (r_cnt == 3'd3) begin
                        r_state <= D_FILL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                D_FILL: if (w_in_xfer) begin
                    if (r_cnt == 3'd3) begin
                        r_state <= PRESENT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                PRESENT: if (w_win_xfer) begin
                    r_state <= SLIDE;
                    r_cnt   <= '0;
                end
                SLIDE: if (w_in_xfer) begin
                    if (r_cnt == SLIDE_LAST) begin
                        r_state <= PRESENT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= K_LOAD;
            endcase
        end
    end

    // Coefficients survive kload; they are only overwritten by a new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_h[i] <= '0;
        end else if (w_in_xfer && r_state == K_LOAD) begin
            r_h[r_cnt[1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_x[i] <= '0;
        end else if (kload || w_klast) begin
            for (int i = 0; i < 4; i++) r_x[i] <= '0;
        end else if (w_shift) begin
            r_x[0] <= r_x[1];
            r_x[1] <= r_x[2];
            r_x[2] <= r_x[3];
            r_x[3] <= in_data;
        end
    end

`ifdef CONV_LOADER_WIN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             win_count <= '0;
        else if (w_win_xfer) win_count <= win_count + 16'd1;
    end
`endif

    assign h0 = r_h[0];
    assign h1 = r_h[1];
    assign h2 = r_h[2];
    assign h3 = r_h[3];
    assign x0 = r_x[0];
    assign x1 = r_x[1];
    assign x2 = r_x[2];
    assign x3 = r_x[3];

endmodule
